// File: rtl/fib_query_arbiter.sv
// fib_query_arbiter: round-robin arbiter sharing one iterative Fibonacci datapath between two requesters.
// Define FIB_SAT_EN to saturate results at 2^W-1 instead of wrapping modulo 2^W.
module fib_query_arbiter #(
    parameter int W  = 20,
    parameter int NW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic [NW-1:0] n0,
    input  logic          req1,
    input  logic [NW-1:0] n1,
    output logic          ack0,
    output logic          ack1,
    output logic [W-1:0]  fn,
    output logic          ovf,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
    state_t state;
    logic [W-1:0] a, b, nxt;
    logic [NW-1:0] cnt, n_lat;
    logic gnt, last, carry, carry_b, pick;
    logic [W:0] sum;
    assign sum  = {1'b0, a} + {1'b0, b};
    assign pick = (req0 & req1) ? ~last : req1;
`ifdef FIB_SAT_EN
    assign nxt = sum[W] ? '1 : sum[W-1:0];
`else
    assign nxt = sum[W-1:0];
`endif
    // carry tracks wraps behind a (the returned value), carry_b those behind b
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            a       <= '0;
            b       <= '0;
            cnt     <= '0;
            n_lat   <= '0;
            gnt     <= 1'b0;
            last    <= 1'b1;
            carry   <= 1'b0;
            carry_b <= 1'b0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            fn      <= '0;
            ovf     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req0 | req1) begin
                    gnt     <= pick;
                    n_lat   <= pick ? n1 : n0;
                    a       <= '0;
                    b       <= W'(1);
                    cnt     <= '0;
                    carry   <= 1'b0;
                    carry_b <= 1'b0;
                    busy    <= 1'b1;
                    state   <= ITER;
                end
                ITER: if (cnt == n_lat) begin
                    fn    <= a;
                    ovf   <= carry;
                    last  <= gnt;
                    ack0  <= ~gnt;
                    ack1  <= gnt;
                    state <= DONE;
                end else begin
                    a       <= b;
                    b       <= nxt;
                    carry   <= carry_b;
                    carry_b <= carry_b | sum[W];
                    cnt     <= cnt + 1'b1;
                end
                DONE: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
